// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// Next-PC source select and the instruction-word to byte shift.
package pc_gen_pkg;
  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_REG,
    SEL_RAS
  } next_pc_sel_t;

  localparam int INSTR_SHIFT = 2;
endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with top pointer, occupancy count and sticky overflow.
// A push while full overwrites the oldest entry; push and pop together replace the top entry.
module return_addr_stack #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full,
  output logic              overflow
);
  import pc_gen_pkg::*;

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d, wr_ptr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              do_pop;

  assign do_pop = pop && (cnt_q != '0);

  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wr_ptr = top_q + PTR_W'(1);
    if (do_pop && push) begin
      // pop then push lands back on the same slot: replace top in place
      wr_ptr = top_q;
    end else if (do_pop) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push) begin
      top_d = top_q + PTR_W'(1);
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= push_data;
  end

  assign top_data = mem_q[top_q];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_MAX);
  assign overflow = ovf_q;
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: PC register, branch target adders, redirect priority and stall gating.
// Return addresses for BL/RET come from the return_addr_stack instance.
module pc_gen #(
  parameter int                ADDR_W    = 64,
  parameter int                COND_W    = 19,
  parameter int                UNCOND_W  = 26,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                br_taken,
  input  logic                uncond_br,
  input  logic [COND_W-1:0]   cond_addr,
  input  logic [UNCOND_W-1:0] br_addr,
  input  logic                link,
  input  logic                ret,
  input  logic                reg_br,
  input  logic [ADDR_W-1:0]   reg_target,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ret_miss,
  output logic                ras_overflow
);
  import pc_gen_pkg::*;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << INSTR_SHIFT) - ADDR_W'(1));

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] cond_off, uncond_off, br_target, reg_aligned, ras_top, next_pc;
  next_pc_sel_t      sel;

  assign cond_off    = {{(ADDR_W-COND_W){cond_addr[COND_W-1]}}, cond_addr};
  assign uncond_off  = {{(ADDR_W-UNCOND_W){br_addr[UNCOND_W-1]}}, br_addr};
  assign br_target   = pc_q + ((uncond_br ? uncond_off : cond_off) << INSTR_SHIFT);
  assign reg_aligned = reg_target & ALIGN_MASK;
  assign pc_plus4    = pc_q + (ADDR_W'(1) << INSTR_SHIFT);

  always_comb begin
    if (reg_br)        sel = SEL_REG;
    else if (ret)      sel = SEL_RAS;
    else if (br_taken) sel = SEL_BRANCH;
    else               sel = SEL_SEQ;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_REG:    next_pc = reg_aligned;
      SEL_RAS:    next_pc = ras_empty ? reg_aligned : ras_top;
      SEL_BRANCH: next_pc = br_target;
      default:    next_pc = pc_plus4;
    endcase
    pc_d = stall ? pc_q : next_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  return_addr_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (link && !stall),
    .pop      (ret && !stall),
    .push_data(pc_plus4),
    .top_data (ras_top),
    .empty    (ras_empty),
    .full     (ras_full),
    .overflow (ras_overflow)
  );

  assign pc       = pc_q;
  assign ret_miss = ret && ras_empty;
endmodule
